// File: rtl/digit_game_if.sv
// Key pulses from the debounced key decoder and the registered game outputs
// consumed by the display and buzzer drivers.
interface digit_game_if #(
  parameter int NUM_CH  = 10,
  parameter int DIGIT_W = 4,
  parameter int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // Key pulses are single-cycle strobes with no ready path: the core acts on
  // every pulse it samples, and all outputs are plain registered levels.
  logic                      key_up;
  logic                      key_down;
  logic                      key_left;
  logic                      key_right;
  logic                      key_ok;
  logic                      key_back;
  logic                      key_help;
  logic [1:0]                state;
  logic [NUM_CH*DIGIT_W-1:0] status;
  logic [CW-1:0]             cursor;
  logic [CW:0]               active_cnt;
  logic [NUM_CH-1:0]         wrap_mask;
  logic                      alarm;

  modport master (
    output key_up, key_down, key_left, key_right, key_ok, key_back, key_help,
    input  state, status, cursor, active_cnt, wrap_mask, alarm
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_ok, key_back, key_help,
    output state, status, cursor, active_cnt, wrap_mask, alarm
  );
endinterface

// File: rtl/digit_game_core.sv
// Menu state machine, NUM_CH modular digit counters with cursor, sticky wrap
// flags and a timed alarm for the digit game.
module digit_game_core #(
  parameter int NUM_CH    = 10,
  parameter int DIGIT_W   = 4,
  parameter int DIGIT_MAX = 9,
  parameter int INIT_VAL  = 1,
  parameter int ALARM_CYC = 50000000,
  parameter int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic        clk,
  input logic        rst,
  digit_game_if.slave io
);
  localparam int AW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_HELP   = 2'd1,
    S_CHOOSE = 2'd2,
    S_PLAY   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    A_NONE, A_BACK, A_OK, A_HELP, A_UP, A_DOWN, A_LEFT, A_RIGHT
  } act_t;

  state_t             state_q;
  logic [DIGIT_W-1:0] dig_q [NUM_CH];
  logic [CW-1:0]      cur_q;
  logic [CW:0]        act_q;
  logic [NUM_CH-1:0]  wrap_q;
  logic [AW-1:0]      cnt_q;
  logic               alarm_q;

  act_t               act;
  logic [AW-1:0]      cnt_nxt;
  logic [DIGIT_W-1:0] cur_dig;
  logic               cur_at_max;

  // Pick the single highest-priority key that means something in this state;
  // keys that do not apply here fall through to lower-priority ones.
  always_comb begin
    act = A_NONE;
    case (state_q)
      S_START: begin
        if (io.key_ok)        act = A_OK;
        else if (io.key_help) act = A_HELP;
      end
      S_HELP: begin
        if (io.key_back)    act = A_BACK;
        else if (io.key_ok) act = A_OK;
      end
      S_CHOOSE: begin
        if (io.key_back)      act = A_BACK;
        else if (io.key_ok)   act = A_OK;
        else if (io.key_up)   act = A_UP;
        else if (io.key_down) act = A_DOWN;
      end
      S_PLAY: begin
        if (io.key_back)       act = A_BACK;
        else if (io.key_ok)    act = A_OK;
        else if (io.key_up)    act = A_UP;
        else if (io.key_down)  act = A_DOWN;
        else if (io.key_left)  act = A_LEFT;
        else if (io.key_right) act = A_RIGHT;
      end
      default: act = A_NONE;
    endcase
  end

  assign cur_dig    = dig_q[cur_q];
  assign cur_at_max = (cur_dig == DIGIT_W'(DIGIT_MAX));

  // Alarm counter runs down in every state; PLAY entry and acknowledge clear
  // it, a wrap (re)loads it.
  always_comb begin
    cnt_nxt = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    if ((state_q == S_CHOOSE || state_q == S_PLAY) && act == A_OK)
      cnt_nxt = '0;
    else if (state_q == S_PLAY && act == A_UP && cur_at_max)
      cnt_nxt = AW'(ALARM_CYC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_START;
      for (int i = 0; i < NUM_CH; i++) dig_q[i] <= DIGIT_W'(INIT_VAL);
      cur_q   <= '0;
      act_q   <= (CW+1)'(1);
      wrap_q  <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_nxt;
      alarm_q <= (cnt_nxt != '0);
      case (state_q)
        S_START: begin
          if (act == A_OK)        state_q <= S_CHOOSE;
          else if (act == A_HELP) state_q <= S_HELP;
        end
        S_HELP: begin
          if (act == A_BACK)    state_q <= S_START;
          else if (act == A_OK) state_q <= S_CHOOSE;
        end
        S_CHOOSE: begin
          case (act)
            A_BACK: state_q <= S_START;
            A_OK: begin
              state_q <= S_PLAY;
              for (int i = 0; i < NUM_CH; i++) dig_q[i] <= DIGIT_W'(INIT_VAL);
              cur_q  <= '0;
              wrap_q <= '0;
            end
            A_UP:   if (act_q != (CW+1)'(NUM_CH)) act_q <= act_q + 1'b1;
            A_DOWN: if (act_q != (CW+1)'(1))      act_q <= act_q - 1'b1;
            default: ;
          endcase
        end
        S_PLAY: begin
          case (act)
            A_BACK: state_q <= S_START;
            A_OK:   wrap_q  <= '0;
            A_UP: begin
              if (cur_at_max) begin
                dig_q[cur_q]  <= '0;
                wrap_q[cur_q] <= 1'b1;
              end else begin
                dig_q[cur_q] <= cur_dig + 1'b1;
              end
            end
            A_DOWN: begin
              if (cur_dig == '0) dig_q[cur_q] <= DIGIT_W'(DIGIT_MAX);
              else               dig_q[cur_q] <= cur_dig - 1'b1;
            end
            A_LEFT: begin
              if (cur_q == '0) cur_q <= CW'(act_q - 1'b1);
              else             cur_q <= cur_q - 1'b1;
            end
            A_RIGHT: begin
              if ({1'b0, cur_q} == act_q - 1'b1) cur_q <= '0;
              else                               cur_q <= cur_q + 1'b1;
            end
            default: ;
          endcase
        end
        default: state_q <= S_START;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign io.status[g*DIGIT_W +: DIGIT_W] = dig_q[g];
  end

  assign io.state      = state_q;
  assign io.cursor     = cur_q;
  assign io.active_cnt = act_q;
  assign io.wrap_mask  = wrap_q;
  assign io.alarm      = alarm_q;
endmodule

// File: tb/tb_digit_game_core.sv
// Directed plus randomized key sequences for digit_game_core, checked every
// cycle against an integer-level model of the game rules.
module tb_digit_game_core;
  localparam int NUM_CH    = 10;
  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;
  localparam int INIT_VAL  = 1;
  localparam int ALARM_CYC = 8;
  localparam int CW        = 4;
  localparam int SW        = NUM_CH * DIGIT_W;

  // Key mask bit order doubles as priority order: back > ok > help > up > down > left > right.
  localparam logic [6:0] K_NONE  = 7'b0000000;
  localparam logic [6:0] K_BACK  = 7'b1000000;
  localparam logic [6:0] K_OK    = 7'b0100000;
  localparam logic [6:0] K_HELP  = 7'b0010000;
  localparam logic [6:0] K_UP    = 7'b0001000;
  localparam logic [6:0] K_DOWN  = 7'b0000100;
  localparam logic [6:0] K_LEFT  = 7'b0000010;
  localparam logic [6:0] K_RIGHT = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_game_if #(.NUM_CH(NUM_CH), .DIGIT_W(DIGIT_W), .CW(CW)) io ();

  digit_game_core #(
    .NUM_CH(NUM_CH), .DIGIT_W(DIGIT_W), .DIGIT_MAX(DIGIT_MAX),
    .INIT_VAL(INIT_VAL), .ALARM_CYC(ALARM_CYC), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [SW-1:0] exp_q[$];

  // Reference model: plain integers, state numbered as on the state output.
  int m_state;
  int m_dig [NUM_CH];
  int m_wrap [NUM_CH];
  int m_cur;
  int m_act;
  int m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit key_applies(int st, int k);
    case (st)
      0:       return (k == 5) || (k == 4);
      1:       return (k == 6) || (k == 5);
      2:       return (k == 6) || (k == 5) || (k == 3) || (k == 2);
      3:       return (k != 4);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_dig[i]  = INIT_VAL;
      m_wrap[i] = 0;
    end
    m_cur = 0;
    m_act = 1;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [6:0] k, input logic r);
    int sel;
    if (r) begin
      model_reset();
      return;
    end
    sel = -1;
    for (int b = 6; b >= 0; b--)
      if (sel < 0 && k[b] && key_applies(m_state, b)) sel = b;
    if (m_cnt > 0) m_cnt--;
    case (sel)
      6: m_state = 0;
      5: begin
        if (m_state == 0 || m_state == 1) m_state = 2;
        else if (m_state == 2) begin
          m_state = 3;
          for (int i = 0; i < NUM_CH; i++) begin
            m_dig[i]  = INIT_VAL;
            m_wrap[i] = 0;
          end
          m_cur = 0;
          m_cnt = 0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) m_wrap[i] = 0;
          m_cnt = 0;
        end
      end
      4: m_state = 1;
      3: begin
        if (m_state == 2) m_act = (m_act < NUM_CH) ? m_act + 1 : NUM_CH;
        else begin
          m_dig[m_cur] = (m_dig[m_cur] + 1) % (DIGIT_MAX + 1);
          if (m_dig[m_cur] == 0) begin
            m_wrap[m_cur] = 1;
            m_cnt = ALARM_CYC;
          end
        end
      end
      2: begin
        if (m_state == 2) m_act = (m_act > 1) ? m_act - 1 : 1;
        else m_dig[m_cur] = (m_dig[m_cur] + DIGIT_MAX) % (DIGIT_MAX + 1);
      end
      1: m_cur = (m_cur + m_act - 1) % m_act;
      0: m_cur = (m_cur + 1) % m_act;
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [SW-1:0]     s;
    logic [NUM_CH-1:0] w;
    int                d;
    for (int i = 0; i < NUM_CH; i++) begin
      d = m_dig[i];
      s[i*DIGIT_W +: DIGIT_W] = d[DIGIT_W-1:0];
      w[i] = (m_wrap[i] != 0);
    end
    exp_q.push_back(s);
    chk("state",      64'(io.state),      64'(m_state));
    chk("status",     64'(io.status),     64'(exp_q.pop_front()));
    chk("cursor",     64'(io.cursor),     64'(m_cur));
    chk("active_cnt", 64'(io.active_cnt), 64'(m_act));
    chk("wrap_mask",  64'(io.wrap_mask),  64'(w));
    chk("alarm",      64'(io.alarm),      64'(m_cnt != 0));
  endtask

  task automatic cycle(input logic [6:0] k, input logic r = 1'b0);
    @(negedge clk);
    {io.key_back, io.key_ok, io.key_help, io.key_up,
     io.key_down, io.key_left, io.key_right} = k;
    rst = r;
    @(posedge clk);
    #1;
    {io.key_back, io.key_ok, io.key_help, io.key_up,
     io.key_down, io.key_left, io.key_right} = K_NONE;
    rst = 1'b0;
    model_step(k, r);
    check_all();
  endtask

  initial begin
    int hi;
    logic [6:0] k;
    logic       r;
    {io.key_back, io.key_ok, io.key_help, io.key_up,
     io.key_down, io.key_left, io.key_right} = K_NONE;
    model_reset();

    // Reset values
    cycle(K_NONE, 1'b1);
    cycle(K_NONE, 1'b1);
    chk("rst_state",  64'(io.state),  64'd0);
    chk("rst_status", 64'(io.status), 64'h1111111111);
    chk("rst_alarm",  64'(io.alarm),  64'd0);

    // Choose four channels, then cursor wraps both ways
    cycle(K_OK);
    repeat (3) cycle(K_UP);
    cycle(K_OK);
    chk("play_state", 64'(io.state),      64'd3);
    chk("play_cnt",   64'(io.active_cnt), 64'd4);
    cycle(K_LEFT);
    chk("left_wrap", 64'(io.cursor), 64'd3);
    cycle(K_RIGHT);
    chk("right_wrap", 64'(io.cursor), 64'd0);

    // Nine ups wrap digit0 and fire the alarm for ALARM_CYC cycles
    repeat (9) cycle(K_UP);
    chk("wrap_digit", 64'(io.status[3:0]), 64'd0);
    chk("wrap_mask0", 64'(io.wrap_mask),   64'h001);
    chk("alarm_rise", 64'(io.alarm),       64'd1);
    hi = 1;
    repeat (12) begin
      cycle(K_NONE);
      if (io.alarm) hi++;
    end
    chk("alarm_len", 64'(hi), 64'(ALARM_CYC));

    // Down wraps 0 -> DIGIT_MAX without alarm
    cycle(K_OK);
    cycle(K_UP);
    cycle(K_DOWN);
    chk("down_to0", 64'(io.status[3:0]), 64'd0);
    cycle(K_DOWN);
    chk("down_wrap",  64'(io.status[3:0]), 64'd9);
    chk("down_alarm", 64'(io.alarm),       64'd0);
    chk("down_mask",  64'(io.wrap_mask),   64'd0);

    // Simultaneous keys resolve by priority
    cycle(K_BACK | K_UP);
    chk("back_up_state", 64'(io.state),       64'd0);
    chk("back_up_digit", 64'(io.status[3:0]), 64'd9);
    cycle(K_OK | K_HELP);
    chk("ok_help_state", 64'(io.state), 64'd2);

    // Reset during an active alarm
    cycle(K_OK);
    repeat (9) cycle(K_UP);
    chk("pre_rst_alarm", 64'(io.alarm), 64'd1);
    cycle(K_NONE, 1'b1);
    chk("mid_rst_alarm",  64'(io.alarm),  64'd0);
    chk("mid_rst_state",  64'(io.state),  64'd0);
    chk("mid_rst_status", 64'(io.status), 64'h1111111111);

    // active_cnt saturates at both ends
    cycle(K_OK);
    repeat (12) cycle(K_UP);
    chk("cnt_sat_hi", 64'(io.active_cnt), 64'(NUM_CH));
    repeat (12) cycle(K_DOWN);
    chk("cnt_sat_lo", 64'(io.active_cnt), 64'd1);

    // Random key storms with occasional resets
    repeat (800) begin
      for (int b = 0; b < 7; b++) k[b] = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      cycle(k, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/digit_game_core.md
Name: digit_game_core

Overview:
- Parametrised successor to the fixed 10-digit game controller.
- Holds NUM_CH modular digit counters and runs the menu state machine (start / help / choose count / play).
- Moves a cursor over the active channels and drives a timed alarm when any digit wraps from its maximum to 0.
- Sits between the debounced matrix-key decoder and the seven-segment/VGA display and buzzer drivers.

Parameters:
- NUM_CH, 10: number of digit channels.
- DIGIT_W, 4: bits per digit.
- DIGIT_MAX, 9: largest digit value; must satisfy DIGIT_MAX < 2**DIGIT_W.
- INIT_VAL, 1: value each digit is loaded with at reset and on entry to PLAY.
- ALARM_CYC, 50000000: alarm duration in clk cycles (1 s at 50 MHz).
- CW, $clog2(NUM_CH) (minimum 1): cursor width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_up  in  1  single-cycle key pulse (debounced, edge-detected upstream).
- key_down  in  1  pulse.
- key_left  in  1  pulse.
- key_right  in  1  pulse.
- key_ok  in  1  pulse: confirm / acknowledge.
- key_back  in  1  pulse: exit to start screen.
- key_help  in  1  pulse: open help screen.
- state  out  2  0=START, 1=HELP, 2=CHOOSE, 3=PLAY.
- status  out  NUM_CH*DIGIT_W  packed digits; channel i occupies [i*DIGIT_W +: DIGIT_W].
- cursor  out  CW  selected channel.
- active_cnt  out  CW+1  number of active channels, range 1..NUM_CH.
- wrap_mask  out  NUM_CH  sticky per-channel wrap flags.
- alarm  out  1  buzzer enable.

Behaviour:
- All outputs are registered. Every key takes effect on the clk edge that samples the pulse, and the outputs show the result in the following cycle.
- Reset values:
  - state=START
  - every digit=INIT_VAL
  - cursor=0
  - active_cnt=1
  - wrap_mask=0
  - alarm=0, alarm counter=0
- Rule for several keys high in one cycle: only the single highest-priority applicable key acts.
  - Priority order: back > ok > help > up > down > left > right.
  - Keys that do not apply in the current state are ignored and do not block lower-priority keys.
- START:
  - help -> HELP.
  - ok -> CHOOSE.
- HELP:
  - back -> START.
  - ok -> CHOOSE.
- CHOOSE:
  - up: active_cnt+1, saturating at NUM_CH.
  - down: active_cnt-1, saturating at 1.
  - ok -> PLAY. On entry: all digits=INIT_VAL, cursor=0, wrap_mask=0, alarm counter=0.
  - back -> START.
- PLAY:
  - back -> START. Digits, wrap_mask and alarm are held; the alarm keeps counting down.
  - ok: acknowledge. Clears wrap_mask and the alarm counter (alarm falls the next cycle). State unchanged.
  - up: digit[cursor] increments. At DIGIT_MAX it becomes 0, wrap_mask[cursor] is set, and the alarm counter is loaded with ALARM_CYC. A retrigger while the alarm is active reloads the counter.
  - down: digit[cursor] decrements. At 0 it becomes DIGIT_MAX. No alarm, and the wrap flag is untouched.
  - left: cursor-1; from 0 it wraps to active_cnt-1.
  - right: cursor+1; from active_cnt-1 it wraps to 0.
- Channels with index >= active_cnt are never modified in PLAY.
- Alarm:
  - alarm = (alarm counter != 0).
  - The counter decrements by 1 every cycle while nonzero, in any state.
  - rst clears the counter immediately.
- rst asserted in any state, including mid-alarm or mid-key, overrides all keys and reapplies the reset values on that edge.
- Arithmetic is in DIGIT_W bits. Values above DIGIT_MAX never occur.

Test Plan:
1. Reset, then check outputs -> state=0, status=0x1111111111, cursor=0, active_cnt=1, alarm=0.
2. ok, then up x3 in CHOOSE, then ok -> state=3, active_cnt=4. Then left once -> cursor=3 (wrap). Then right once -> cursor=0.
3. In PLAY with cursor=0, up x9 -> digit0 steps 2..9 then 0. On the 9th pulse wrap_mask=0x001 and alarm rises the next cycle. alarm stays high exactly ALARM_CYC cycles; use ALARM_CYC=8 in the bench.
4. In PLAY with cursor=0 and digit0=1, down x2 -> digit0=0, then 9. alarm stays 0 and wrap_mask stays 0.
5. key_back and key_up asserted in the same PLAY cycle -> state=START and the digit is unchanged. Then key_ok and key_help together in START -> state=CHOOSE.
6. rst pulsed while alarm is active in PLAY -> the next cycle shows alarm=0, state=START, and all digits back at INIT_VAL.
